// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sphere-decoder cost path.
// Covers the 8-PAM symbol map and the channel-word load address map.
package sd_pkg;

    localparam int SD_WIDTH     = 20;
    localparam int N_CHAN_WORDS = 14;

    // Upper-triangular R is stored row by row, followed by z0..z3.
    localparam logic [3:0] ADDR_R00 = 4'd0;
    localparam logic [3:0] ADDR_R01 = 4'd1;
    localparam logic [3:0] ADDR_R02 = 4'd2;
    localparam logic [3:0] ADDR_R03 = 4'd3;
    localparam logic [3:0] ADDR_R11 = 4'd4;
    localparam logic [3:0] ADDR_R12 = 4'd5;
    localparam logic [3:0] ADDR_R13 = 4'd6;
    localparam logic [3:0] ADDR_R22 = 4'd7;
    localparam logic [3:0] ADDR_R23 = 4'd8;
    localparam logic [3:0] ADDR_R33 = 4'd9;
    localparam logic [3:0] ADDR_Z0  = 4'd10;
    localparam logic [3:0] ADDR_Z1  = 4'd11;
    localparam logic [3:0] ADDR_Z2  = 4'd12;
    localparam logic [3:0] ADDR_Z3  = 4'd13;

    // idx 0..7 -> -7..+7; the 4-bit wraparound gives the correct two's-complement value.
    function automatic logic signed [3:0] pam_map(input logic [2:0] idx);
        logic [3:0] t;
        t = {idx, 1'b0} - 4'd7;
        return signed'(t);
    endfunction

endpackage

// File: rtl/ped_level_metric.sv
// Squared, scaled and saturated error of one tree level.
// Row entries left of the diagonal are masked by the level select.
module ped_level_metric
    import sd_pkg::*;
#(
    parameter int COEF_W = 8,
    parameter int WIDTH  = SD_WIDTH,
    parameter int SHIFT  = 4
) (
    input  logic        [1:0]        lvl,
    input  logic signed [COEF_W-1:0] r0,
    input  logic signed [COEF_W-1:0] r1,
    input  logic signed [COEF_W-1:0] r2,
    input  logic signed [COEF_W-1:0] r3,
    input  logic signed [COEF_W-1:0] z_k,
    input  logic signed [3:0]        s0,
    input  logic signed [3:0]        s1,
    input  logic signed [3:0]        s2,
    input  logic signed [3:0]        s3,
    output logic        [WIDTH-1:0]  metric
);

    localparam int PW = COEF_W + 4;
    localparam int SW = COEF_W + 7;
    localparam int QW = 2 * SW;

    logic signed [PW-1:0] prod [4];
    logic signed [SW-1:0] acc;
    logic signed [QW-1:0] acc_ext;
    logic signed [QW-1:0] sq;
    logic        [QW-1:0] shifted;

    always_comb begin
        prod[0] = PW'(r0) * PW'(s0);
        prod[1] = PW'(r1) * PW'(s1);
        prod[2] = PW'(r2) * PW'(s2);
        prod[3] = PW'(r3) * PW'(s3);
        acc = SW'(z_k);
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(lvl)) begin
                acc = acc - SW'(prod[j]);
            end
        end
        acc_ext = QW'(acc);
        sq      = acc_ext * acc_ext;
        // The square is never negative, so a logical shift equals the arithmetic one.
        shifted = unsigned'(sq) >> SHIFT;
        if (|shifted[QW-1:WIDTH]) begin
            metric = '1;
        end else begin
            metric = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ped_cost_unit.sv
// Partial Euclidean distance of the enumerator's current node.
// Holds the shadow and active channel banks, the per-level PED stack and the bank promotion.
module ped_cost_unit
    import sd_pkg::*;
#(
    parameter int WIDTH  = SD_WIDTH,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic        [2:0]        node0,
    input  logic        [2:0]        node1,
    input  logic        [2:0]        node2,
    input  logic        [2:0]        node3,
    input  logic        [1:0]        node_lvl,
    input  logic                     search_done,
    input  logic                     load_valid,
    input  logic        [3:0]        load_addr,
    input  logic signed [COEF_W-1:0] load_data,
    output logic                     channel_ready,
    output logic                     shadow_full,
    output logic        [WIDTH-1:0]  current_node_cost
);

    logic signed [COEF_W-1:0]  sh_q   [N_CHAN_WORDS];
    logic signed [COEF_W-1:0]  sh_d   [N_CHAN_WORDS];
    logic signed [COEF_W-1:0]  act_q  [N_CHAN_WORDS];
    logic signed [COEF_W-1:0]  act_d  [N_CHAN_WORDS];
    logic [N_CHAN_WORDS-1:0]   mask_q, mask_d;
    logic                      shadow_full_q, shadow_full_d;
    logic                      ready_q, ready_d;
    logic [WIDTH-1:0]          stack_q [1:3];
    logic [WIDTH-1:0]          stack_d [1:3];

    logic                      promote;
    logic signed [COEF_W-1:0]  r_sel [4];
    logic signed [COEF_W-1:0]  z_sel;
    logic signed [3:0]         sym   [4];
    logic [WIDTH-1:0]          metric;
    logic [WIDTH-1:0]          parent;
    logic [WIDTH:0]            sum;
    logic [WIDTH-1:0]          cost;

    assign sym[0] = pam_map(node0);
    assign sym[1] = pam_map(node1);
    assign sym[2] = pam_map(node2);
    assign sym[3] = pam_map(node3);

    always_comb begin
        r_sel = '{default: '0};
        z_sel = '0;
        case (node_lvl)
            2'd0: begin
                r_sel[0] = act_q[ADDR_R00];
                r_sel[1] = act_q[ADDR_R01];
                r_sel[2] = act_q[ADDR_R02];
                r_sel[3] = act_q[ADDR_R03];
                z_sel    = act_q[ADDR_Z0];
            end
            2'd1: begin
                r_sel[1] = act_q[ADDR_R11];
                r_sel[2] = act_q[ADDR_R12];
                r_sel[3] = act_q[ADDR_R13];
                z_sel    = act_q[ADDR_Z1];
            end
            2'd2: begin
                r_sel[2] = act_q[ADDR_R22];
                r_sel[3] = act_q[ADDR_R23];
                z_sel    = act_q[ADDR_Z2];
            end
            default: begin
                r_sel[3] = act_q[ADDR_R33];
                z_sel    = act_q[ADDR_Z3];
            end
        endcase
    end

    ped_level_metric #(
        .COEF_W (COEF_W),
        .WIDTH  (WIDTH),
        .SHIFT  (SHIFT)
    ) u_metric (
        .lvl    (node_lvl),
        .r0     (r_sel[0]),
        .r1     (r_sel[1]),
        .r2     (r_sel[2]),
        .r3     (r_sel[3]),
        .z_k    (z_sel),
        .s0     (sym[0]),
        .s1     (sym[1]),
        .s2     (sym[2]),
        .s3     (sym[3]),
        .metric (metric)
    );

    always_comb begin
        case (node_lvl)
            2'd0:    parent = stack_q[1];
            2'd1:    parent = stack_q[2];
            2'd2:    parent = stack_q[3];
            default: parent = '0;
        endcase
        sum = {1'b0, parent} + {1'b0, metric};
        // Without a channel the enumerator must see an unreachable cost and stay at the root.
        if (!ready_q || sum[WIDTH]) begin
            cost = '1;
        end else begin
            cost = sum[WIDTH-1:0];
        end
    end

    always_comb begin
        sh_d    = sh_q;
        act_d   = act_q;
        mask_d  = mask_q;
        ready_d = ready_q;
        stack_d = stack_q;
        promote = shadow_full_q && (!ready_q || search_done);

        if (promote) begin
            act_d   = sh_q;
            mask_d  = '0;
            ready_d = 1'b1;
        end

        if (promote || search_done) begin
            stack_d = '{default: '0};
        end else if (ready_q) begin
            case (node_lvl)
                2'd1:    stack_d[1] = cost;
                2'd2:    stack_d[2] = cost;
                2'd3:    stack_d[3] = cost;
                default: ;
            endcase
        end

        // A write on the promotion edge lands in the freshly cleared shadow.
        if (load_valid && (load_addr <= ADDR_Z3)) begin
            sh_d[load_addr]   = load_data;
            mask_d[load_addr] = 1'b1;
        end

        shadow_full_d = !promote && (&mask_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sh_q          <= '{default: '0};
            act_q         <= '{default: '0};
            mask_q        <= '0;
            shadow_full_q <= 1'b0;
            ready_q       <= 1'b0;
            stack_q       <= '{default: '0};
        end else begin
            sh_q          <= sh_d;
            act_q         <= act_d;
            mask_q        <= mask_d;
            shadow_full_q <= shadow_full_d;
            ready_q       <= ready_d;
            stack_q       <= stack_d;
        end
    end

    assign channel_ready     = ready_q;
    assign shadow_full       = shadow_full_q;
    assign current_node_cost = cost;

endmodule
